// File: rtl/wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer
//
// Adds two W-bit operands (W = SIZE*WORDS) one SIZE-bit slice per cycle. The
// same SIZE-bit carry-lookahead slice is reused for every cycle, and the carry
// is passed from one cycle to the next. The operands and carry_in are latched
// when start is accepted in IDLE. RUN then lasts exactly WORDS cycles. DONE
// raises done for one cycle. sum and carry_out change only on the RUN->DONE
// transition.
//
// Parameters
//   SIZE       slice width in bits (default 4)
//   WORDS      slices per operand, >= 2 (default 4)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin an addition (sampled only in IDLE)
//   sub        (only with WIDE_ADD_SEQUENCER_SUB_EN) subtract in_2 instead of
//              adding it; sampled with start
//   in_1       operand A
//   in_2       operand B
//   carry_in   initial carry
//   busy       high while in RUN
//   done       one-cycle pulse marking a valid sum/carry_out
//   sum        result register (modulo 2^W)
//   carry_out  carry out of the last slice (1 = no borrow when subtracting)
//
// Optional feature: define WIDE_ADD_SEQUENCER_SUB_EN to add the sub port.
// ---------------------------------------------------------------------------
module wide_add_sequencer #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
  input  logic                  sub,
`endif
  input  logic [SIZE*WORDS-1:0] in_1,
  input  logic [SIZE*WORDS-1:0] in_2,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE*WORDS-1:0] sum,
  output logic                  carry_out
);

  localparam int W  = SIZE * WORDS;
  localparam int KW = $clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_q, b_q, acc_q, acc_next;
  logic            c_q;
  logic [KW-1:0]   k_q;

  // Operand selection at acceptance time.
  logic [W-1:0]    b_sel;
  logic            c_sel;

`ifdef WIDE_ADD_SEQUENCER_SUB_EN
  // A - B = A + ~B + 1. The forced carry replaces carry_in.
  assign b_sel = sub ? ~in_2 : in_2;
  assign c_sel = sub | carry_in;
`else
  assign b_sel = in_2;
  assign c_sel = carry_in;
`endif

  // SIZE-bit carry-lookahead slice. Each carry is built directly from the
  // generate/propagate terms and the incoming carry. No carry ripples through
  // another bit's carry.
  logic [SIZE-1:0] g, p, slice_sum;
  logic [SIZE:0]   cy;
  logic            pp;

  always_comb begin
    // NOTE: every variable gets a default before any conditional logic, so
    // no path leaves a value unassigned and no latch is inferred.
    g     = a_q[SIZE-1:0] & b_q[SIZE-1:0];
    p     = a_q[SIZE-1:0] ^ b_q[SIZE-1:0];
    cy    = '0;
    pp    = 1'b0;
    cy[0] = c_q;
    for (int i = 0; i < SIZE; i++) begin
      cy[i+1] = g[i];
      pp      = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cy[i+1] = cy[i+1] | (pp & g[j]);
        pp      = pp & p[j];
      end
      cy[i+1] = cy[i+1] | (pp & c_q);
    end
    slice_sum = p ^ cy[SIZE-1:0];
  end

  // Operands shift down one slice per cycle, so the active slice is always
  // at bit 0. Results enter the accumulator at the top. After WORDS cycles,
  // slice k sits at word k.
  assign acc_next = {slice_sum, acc_q[W-1:SIZE]};

  // Next-state logic and outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (k_q == K_LAST) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  // This way every register samples its value from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well. The reset values of
      // sum/carry_out are visible, and a clean accumulator keeps runs after a
      // reset independent of any aborted run.
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      k_q       <= '0;
      acc_q     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q <= in_1;
            b_q <= b_sel;
            c_q <= c_sel;
            k_q <= '0;
          end
        end
        S_RUN: begin
          a_q   <= a_q >> SIZE;
          b_q   <= b_q >> SIZE;
          c_q   <= cy[SIZE];
          acc_q <= acc_next;
          k_q   <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            sum       <= acc_next;
            carry_out <= cy[SIZE];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wide_add_sequencer
//
// Self-checking bench for wide_add_sequencer (SIZE=4, WORDS=4). The reference
// is plain W+1-bit arithmetic on the operands. Sampling happens on the falling
// edge, and inputs are driven on the falling edge or just after a rising edge.
// Define WIDE_ADD_SEQUENCER_SUB_EN for both the bench and the RTL to cover the
// subtract mode.
// ---------------------------------------------------------------------------
module tb_wide_add_sequencer;

  localparam int SIZE  = 4;
  localparam int WORDS = 4;
  localparam int W     = SIZE * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] in_1, in_2;
  logic         carry_in;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
    .sub       (sub),
`endif
    .in_1      (in_1),
    .in_2      (in_2),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // Reference: {carry, sum} of A + B + cin, or A + ~B + 1 when subtracting.
  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    return r;
  endfunction

  // Runs one operation and reports what was observed. When noise is set,
  // start is pulsed with random operands during RUN. The operand inputs are
  // always scrambled right after acceptance.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic s, input bit noise,
                       output logic [W-1:0] r_sum, output logic r_c,
                       output int busy_cnt, output int lat, output int done_cnt,
                       output bit partial);
    logic [W-1:0] sum_before;
    @(negedge clk);
    start = 1'b1; in_1 = a; in_2 = b; carry_in = cin; sub = s;
    sum_before = sum;
    @(posedge clk); #1;
    start = 1'b0; in_1 = W'($urandom); in_2 = W'($urandom);
    carry_in = 1'($urandom); sub = 1'($urandom);
    busy_cnt = 0; lat = 0; done_cnt = 0; partial = 1'b0;
    r_sum = 'x; r_c = 1'bx;
    for (int i = 1; i <= WORDS + 8; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (sum !== sum_before) partial = 1'b1;
      end
      if (done) begin
        done_cnt++;
        if (lat == 0) begin
          lat = i; r_sum = sum; r_c = carry_out;
        end
      end
      if (noise && busy) begin
        start = 1'b1; in_1 = W'($urandom); in_2 = W'($urandom); carry_in = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  // Checks one completed operation against the reference model.
  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic s, input bit noise);
    logic [W-1:0] r_sum; logic r_c; int bc, lat, dc; bit part;
    logic [W:0] exp;
    exp = ref_result(a, b, cin, s);
    do_op(a, b, cin, s, noise, r_sum, r_c, bc, lat, dc, part);
    checks++;
    if (r_sum !== exp[W-1:0]) begin
      errors++; $display("FAIL %s sum: got %h expected %h", name, r_sum, exp[W-1:0]);
    end
    checks++;
    if (r_c !== exp[W]) begin
      errors++; $display("FAIL %s carry_out: got %b expected %b", name, r_c, exp[W]);
    end
    checks++;
    if (bc !== WORDS) begin
      errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, bc, WORDS);
    end
    checks++;
    if (lat !== WORDS + 1) begin
      errors++; $display("FAIL %s done latency: got %0d expected %0d", name, lat, WORDS + 1);
    end
    checks++;
    if (dc !== 1) begin
      errors++; $display("FAIL %s done pulses: got %0d expected 1", name, dc);
    end
    checks++;
    if (part) begin
      errors++; $display("FAIL %s sum changed during RUN: got 1 expected 0", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; in_1 = '0; in_2 = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, carry_out} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got busy=%b done=%b sum=%h c=%b expected all 0",
               busy, done, sum, carry_out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    check_op("ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check_op("1234+4321+1", 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
    check_op("ffff+ffff+1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    check_op("0000+0000", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      check_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    check_op("start during RUN", 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    int seen;
    // Leave a known nonzero result so the reset clear is observable.
    check_op("pre-reset", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; in_1 = 16'h7777; in_2 = 16'h1111; carry_in = 1'b0; sub = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;         // now in the second RUN cycle
    rst = 1'b1; #1;
    checks++;
    if ({busy, done, sum, carry_out} !== '0) begin
      errors++;
      $display("FAIL mid-run reset: got busy=%b done=%b sum=%h c=%b expected all 0",
               busy, done, sum, carry_out);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL aborted op activity: got %0d cycles expected 0", seen);
    end
    check_op("post-reset 1+1", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    check_op("sub 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    check_op("sub 7-5", 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++)
      check_op("random add/sub", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    int pos[3];
    int npulse;
    logic [W:0] exp;
    exp = ref_result(16'h1357, 16'h2468, 1'b1, 1'b0);
    npulse = 0;
    @(negedge clk);
    start = 1'b1; in_1 = 16'h1357; in_2 = 16'h2468; carry_in = 1'b1; sub = 1'b0;
    for (int i = 0; i < 60 && npulse < 3; i++) begin
      @(negedge clk);
      if (done) begin
        pos[npulse] = i;
        npulse++;
        checks++;
        if (sum !== exp[W-1:0]) begin
          errors++; $display("FAIL back-to-back sum: got %h expected %h", sum, exp[W-1:0]);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (npulse !== 3) begin
      errors++; $display("FAIL back-to-back pulses within bound: got %0d expected 3", npulse);
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (pos[k] - pos[k-1] !== WORDS + 2) begin
          errors++;
          $display("FAIL back-to-back spacing: got %0d expected %0d", pos[k] - pos[k-1], WORDS + 2);
        end
      end
    end
    repeat (WORDS + 3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_mid_reset();
`ifdef WIDE_ADD_SEQUENCER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL take parameter SIZE, default 4, the width in bits of the adder slice processed per cycle.
REQ-002 The block SHALL take parameter WORDS, default 4, the number of slices per operand (operand width W = SIZE*WORDS); WORDS >= 2.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-006 Port in_1  input  W  operand A, sampled on the accepted start.
REQ-007 Port in_2  input  W  operand B, sampled on the accepted start.
REQ-008 Port carry_in  input  1  initial carry, sampled on the accepted start.
REQ-009 Port busy  output  1  high while in RUN.
REQ-010 Port done  output  1  one-cycle pulse marking a valid result.
REQ-011 Port sum  output  W  result register.
REQ-012 Port carry_out  output  1  final carry of the last slice.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, one-hot or binary at implementer choice.
REQ-014 In IDLE with start=1 it SHALL:
- latch in_1, in_2 and carry_in;
- clear slice index k to 0;
- go to RUN.
REQ-015 In IDLE with start=0 it SHALL stay in IDLE.
REQ-016 In RUN, each cycle SHALL use one SIZE-bit carry-lookahead slice to compute A[k]+B[k]+c.
- The SIZE-bit slice result is written to accumulator word k.
- The slice carry-out becomes c for the next cycle.
- k increments.
REQ-017 After the cycle with k = WORDS-1 the FSM SHALL go to DONE; RUN lasts exactly WORDS cycles.
REQ-018 On the transition RUN->DONE:
- the full accumulator SHALL load into sum;
- the final carry SHALL load into carry_out.
REQ-019 DONE SHALL last one cycle with done=1 and then return to IDLE unconditionally.
REQ-020 Latency: with start accepted at edge t, done SHALL be high in the cycle following edge t+WORDS.
REQ-021 start SHALL be ignored in RUN and DONE; there is no queuing and no error flag.
REQ-022 sum and carry_out SHALL hold their last result until the next RUN->DONE transition; partial slice results are never visible on sum.
REQ-023 Arithmetic SHALL be modulo 2^W; overflow is reported only through carry_out.
REQ-024 Operand changes on in_1, in_2 or carry_in after acceptance SHALL NOT affect the running operation.

Reset
REQ-025 rst=1 SHALL immediately force:
- state IDLE, k=0, internal carry 0;
- busy=0, done=0, sum=0, carry_out=0.
REQ-026 A reset asserted mid-RUN SHALL abort the operation with no done pulse and no update of sum.
REQ-027 After rst deasserts, the first start sampled on a rising edge SHALL be accepted normally.

Configuration
REQ-028 Macro WIDE_ADD_SEQUENCER_SUB_EN SHALL, when defined, add port sub (input, 1), sampled with start.
REQ-029 With the macro defined and sub=1:
- B SHALL be taken as ~in_2;
- the initial carry SHALL be forced to 1 and carry_in ignored;
- sum = A-B mod 2^W, with carry_out=1 meaning no borrow.
REQ-030 With the macro defined and sub=0, behaviour SHALL be identical to the macro-undefined build.
REQ-031 Without the macro the sub port SHALL NOT exist and the block SHALL only add.

Verification (SIZE=4, WORDS=4)
REQ-032 start with in_1=0xFFFF, in_2=0x0001, carry_in=0 -> busy for 4 cycles, then done pulse with sum=0x0000, carry_out=1.
REQ-033 start with in_1=0x1234, in_2=0x4321, carry_in=1 -> sum=0x5556, carry_out=0, done exactly 5 cycles after start is sampled.
REQ-034 start pulsed again during RUN with different operands -> ignored; result matches the first operands; exactly one done pulse.
REQ-035 rst asserted in the 2nd RUN cycle -> busy=0, done=0, sum=0 immediately; no done; a next start of 0x0001+0x0001 yields sum=0x0002.
REQ-036 With WIDE_ADD_SEQUENCER_SUB_EN, sub=1, in_1=0x0005, in_2=0x0007 -> sum=0xFFFE, carry_out=0; with in_1=0x0007, in_2=0x0005 -> sum=0x0002, carry_out=1.
REQ-037 start held high continuously -> a new operation is accepted in each IDLE cycle following DONE, giving one done pulse every WORDS+2 cycles.
